ifetch_prefetch_buffer: RTL and testbench

Instruction prefetch unit sitting directly upstream of the IF/ID pipeline register in the pipelined RV64 core. It issues sequential fetch requests to a variable-latency instruction memory over a valid/ready request channel, accepts in-order responses into a DEPTH-entry FIFO and presents one `{pc, instruction}` pair per cycle to IF/ID. It honours the pipeline `stall` and the branch redirect (`branch_taken`/`branch_target` from EX/MEM), discarding stale queued and in-flight instructions on a redirect.

---
 rtl/ifetch_prefetch_buffer.sv | 107 ++++++++++
 tb/tb_ifetch_prefetch_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer feeding IF/ID.
// Sequential fetch with in-order responses, a small FIFO and redirect flush.
module ifetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [63:0] pc,
  output logic [31:0] instruction,
  output logic        instruction_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [63:0]   target;
  logic [63:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] inflight_nxt;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          resp_acc;
  logic          push;
  logic          pop;

  assign target = branch_target & ~64'h3;

  // Queued plus outstanding fetches never exceed the FIFO size,
  // so a response always has a free slot.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !rst && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_acc = imem_resp_valid && (inflight != '0);
  assign push     = resp_acc && (drop == '0) && !branch_taken;
  assign pop      = instruction_valid && !stall && !branch_taken;

  assign inflight_nxt = inflight + CW'(req_fire) - CW'(resp_acc);

  assign instruction_valid = (count != '0);
  assign pc          = instruction_valid ? buf_pc[rd_ptr] : 64'h0;
  assign instruction = instruction_valid ? buf_instr[rd_ptr] : NOP;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (branch_taken) begin
        // Everything still outstanding belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight_nxt;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 64'd4;
        if (resp_acc && (drop != '0))
          drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 64'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (!push && pop)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= resp_pc;
      buf_instr[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Bench for ifetch_prefetch_buffer: memory model, epoch-tagged
// stream model checked every cycle, plus directed literal checks.
module tb_ifetch_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        instruction_valid;

  int checks = 0;
  int failures = 0;

  ifetch_prefetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .pc(pc),
    .instruction(instruction),
    .instruction_valid(instruction_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory: fixed latency per request, in-order, one response per cycle
  typedef struct {
    int          due;
    logic [63:0] addr;
  } mreq_t;
  mreq_t mq[$];
  mreq_t mr;
  int    lat = 1;
  int    cyc = 0;

  always @(negedge clk) begin
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      mr.due  = cyc + lat;
      mr.addr = imem_req_addr;
      mq.push_back(mr);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memw(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // Model: visible pcs queue, pending requests tagged with path epoch
  typedef struct {
    logic [63:0] pc;
    int          ep;
  } pend_t;
  logic [63:0] q[$];
  pend_t       pend[$];
  pend_t       pe;
  logic [63:0] nf = 64'h0;
  int          ep = 0;
  bit          seen = 1'b0;
  bit          erv;
  bit          hs;
  bit          popm;

  always @(negedge clk) begin
    erv = !rst && ((q.size() + pend.size()) < DEPTH);
    if (seen) begin
      chk("valid", 64'(instruction_valid), 64'(q.size() != 0));
      chk("pc", pc, (q.size() != 0) ? q[0] : 64'h0);
      chk("instr", 64'(instruction),
          64'((q.size() != 0) ? memw(q[0]) : NOP));
      chk("req_valid", 64'(imem_req_valid), 64'(erv));
      if (erv)
        chk("req_addr", imem_req_addr, nf);
    end
    if (rst) begin
      q.delete();
      pend.delete();
      nf = RPC;
      ep++;
      seen = 1'b1;
    end else begin
      popm = (q.size() != 0) && !stall && !branch_taken;
      hs = erv && imem_req_ready;
      if (popm)
        void'(q.pop_front());
      if (imem_resp_valid && pend.size() != 0) begin
        pe = pend.pop_front();
        if (pe.ep == ep && !branch_taken)
          q.push_back(pe.pc);
      end
      if (hs) begin
        pe.pc = nf;
        pe.ep = ep;
        pend.push_back(pe);
        nf = nf + 64'd4;
      end
      if (branch_taken) begin
        q.delete();
        ep++;
        nf = branch_target & ~64'h3;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [63:0] exp, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (instruction_valid === 1'b1)
        got = 1'b1;
    end
    if (got) begin
      chk(nm, pc, exp);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=%h", nm, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] t);
    branch_taken  = 1'b1;
    branch_target = t;
    tick(1);
    branch_taken = 1'b0;
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_instr", 64'(instruction), 64'(NOP));
    chk("rst_pc", pc, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 64'(imem_req_valid), 64'h1);
    chk("first_req_addr", imem_req_addr, 64'h1000);
    wait_pc(64'h1000, "stream0");
    wait_pc(64'h1004, "stream1");
    wait_pc(64'h1008, "stream2");
    tick(5);

    stall = 1'b1;
    tick(9);
    @(negedge clk);
    chk("cap_req_valid", 64'(imem_req_valid), 64'h0);
    chk("stall_valid", 64'(instruction_valid), 64'h1);
    @(posedge clk);
    #1;
    stall = 1'b0;
    tick(10);

    lat = 3;
    tick(10);
    redirect(64'h2002);
    @(negedge clk);
    chk("redir_valid_low", 64'(instruction_valid), 64'h0);
    wait_pc(64'h2000, "redir0");
    wait_pc(64'h2004, "redir1");

    lat = 1;
    tick(6);
    branch_taken  = 1'b1;
    branch_target = 64'h3000;
    @(negedge clk);
    chk("simul_resp", 64'(imem_resp_valid), 64'h1);
    chk("simul_req", 64'(imem_req_valid), 64'h1);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    wait_pc(64'h3000, "simul0");

    branch_taken  = 1'b1;
    branch_target = 64'h4000;
    tick(1);
    branch_target = 64'h5000;
    tick(1);
    branch_taken = 1'b0;
    wait_pc(64'h5000, "b2b0");
    wait_pc(64'h5004, "b2b1");

    lat = 4;
    imem_req_ready = 1'b0;
    tick(6);
    imem_req_ready = 1'b1;
    tick(2);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    @(negedge clk);
    chk("orphan_ignored", 64'(instruction_valid), 64'h0);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    wait_pc(64'h1000, "restart");

    lat = 1;
    tick(3);
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    wait_pc(64'hFFFF_FFFF_FFFF_FFF8, "wrap0");
    wait_pc(64'hFFFF_FFFF_FFFF_FFFC, "wrap1");
    wait_pc(64'h0, "wrap2");
    wait_pc(64'h4, "wrap3");

    tick(3);
    imem_req_ready = 1'b0;
    tick(5);
    imem_req_ready = 1'b1;
    tick(10);

    lat = 2;
    for (int i = 0; i < 12; i++) begin
      stall = (i % 3 == 0);
      tick(1);
    end
    stall = 1'b0;
    tick(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
